data_descr_sched_rb: RTL and testbench

Descriptor scheduler for the ring-buffer read packeter. It accepts burst commands (length plus discard flag) and tracks the producer write pointer into the sample RAM ring. It issues `{addr, discard}` / `len-1` descriptors only when the full burst is resident, then releases ring space back to the producer as completions return in issue order. An underrun timeout converts a starved command into a zero-span discard, so the DAC front end never stalls indefinitely.

---
 rtl/data_descr_sched_rb.sv | 185 ++++++++++++++++++
 tb/tb_data_descr_sched_rb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_descr_sched_rb.sv
// Descriptor scheduler for the ring-buffer read packeter: waits for a full burst
// to be resident, issues a {addr,discard}/len_m1 descriptor, then frees ring space in completion order.
module data_descr_sched_rb #(
    parameter int RAM_ADDR_WIDTH = 18,
    parameter int DATA_BITS      = 3,
    parameter int OUT_DEPTH_BITS = 3,
    parameter int TIMEOUT_BITS   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TIMEOUT_BITS-1:0]            cfg_timeout,
    input  logic                               s_cmd_valid,
    output logic                               s_cmd_ready,
    input  logic [RAM_ADDR_WIDTH-1:0]          s_cmd_len_m1,
    input  logic                               s_cmd_discard,
    input  logic [RAM_ADDR_WIDTH:0]            s_wptr,
    output logic                               m_descr_valid,
    input  logic                               m_descr_ready,
    output logic [RAM_ADDR_WIDTH+1-DATA_BITS:0] m_descr_addr,
    output logic [RAM_ADDR_WIDTH-1:0]          m_descr_data,
    input  logic                               s_done_valid,
    output logic [RAM_ADDR_WIDTH:0]            m_rptr,
    output logic [OUT_DEPTH_BITS:0]            m_outstanding,
    output logic [31:0]                        stat_issued,
    output logic [31:0]                        stat_underrun
);

    localparam int PW    = RAM_ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << OUT_DEPTH_BITS;

    localparam logic [OUT_DEPTH_BITS:0]   CNT_ONE = 1;
    localparam logic [OUT_DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [TIMEOUT_BITS-1:0]   TMO_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [PW-1:0]                   r_wptr;
    logic [PW-1:0]                   r_iptr;
    logic [PW-1:0]                   r_rptr;
    logic [TIMEOUT_BITS-1:0]         r_cnt;
    logic [RAM_ADDR_WIDTH-1:0]       r_len_m1;
    logic                            r_disc;
    logic [PW-1:0]                   r_span;
    logic                            r_descr_valid;
    logic [RAM_ADDR_WIDTH+1-DATA_BITS:0] r_descr_addr;
    logic [RAM_ADDR_WIDTH-1:0]       r_descr_data;
    logic [PW-1:0]                   r_descr_span;
    logic [PW-1:0]                   r_fifo [DEPTH];
    logic [OUT_DEPTH_BITS-1:0]       r_wr_ptr;
    logic [OUT_DEPTH_BITS-1:0]       r_rd_ptr;
    logic [OUT_DEPTH_BITS:0]         r_count;
    logic [31:0]                     r_stat_issued;
    logic [31:0]                     r_stat_underrun;

    logic [PW-1:0] w_span_in;
    logic [PW-1:0] w_avail;
    logic          w_has_data;
    logic          w_tmo_hit;
    logic          w_cmd_ready;
    logic          w_cmd_fire;
    logic          w_descr_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_issue_data;
    logic          w_issue_tmo;
    logic          w_cnt_inc;

    // Span rounds the burst up to whole RAM beats; a full-ring burst needs the extra wrap bit.
    assign w_span_in    = (PW'(s_cmd_len_m1 >> DATA_BITS) + PW'(1)) << DATA_BITS;
    assign w_avail      = r_wptr - r_iptr;
    assign w_has_data   = (w_avail >= r_span);
    assign w_tmo_hit    = (cfg_timeout != '0) && (r_cnt == (cfg_timeout - TMO_ONE));
    assign w_cmd_ready  = (r_state == S_IDLE) && (r_count[OUT_DEPTH_BITS] == 1'b0);
    assign w_cmd_fire   = s_cmd_valid && w_cmd_ready;
    assign w_descr_fire = r_descr_valid && m_descr_ready;
    assign w_push       = w_descr_fire;
    // A done pulse against an empty FIFO is spurious and must not move the read pointer.
    assign w_pop        = s_done_valid && (r_count != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_issue_data = 1'b0;
        w_issue_tmo  = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_has_data) begin
                    w_issue_data = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end else if (w_tmo_hit) begin
                    w_issue_tmo = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_descr_fire) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wptr          <= '0;
            r_iptr          <= '0;
            r_rptr          <= '0;
            r_cnt           <= '0;
            r_descr_valid   <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_stat_issued   <= '0;
            r_stat_underrun <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= s_wptr;

            if (w_cmd_fire)     r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + TMO_ONE;

            if (w_issue_data || w_issue_tmo) r_descr_valid <= 1'b1;
            else if (w_descr_fire)           r_descr_valid <= 1'b0;

            if (w_descr_fire) begin
                r_iptr        <= r_iptr + r_descr_span;
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (w_issue_tmo) r_stat_underrun <= r_stat_underrun + 32'd1;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_rptr   <= r_rptr + r_fifo[r_rd_ptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Command and descriptor payload: only meaningful while qualified by the FSM, so no reset.
    always_ff @(posedge clk) begin
        if (w_cmd_fire) begin
            r_len_m1 <= s_cmd_len_m1;
            r_disc   <= s_cmd_discard;
            r_span   <= w_span_in;
        end
        if (w_issue_data) begin
            r_descr_addr <= {r_iptr[PW-1:DATA_BITS], r_disc};
            r_descr_data <= r_len_m1;
            r_descr_span <= r_span;
        end else if (w_issue_tmo) begin
            // Starved burst becomes a zero-span discard so iptr stays in step with the producer.
            r_descr_addr <= {r_iptr[PW-1:DATA_BITS], 1'b1};
            r_descr_data <= r_len_m1;
            r_descr_span <= '0;
        end
        if (w_push) r_fifo[r_wr_ptr] <= r_descr_span;
    end

    assign s_cmd_ready   = w_cmd_ready;
    assign m_descr_valid = r_descr_valid;
    assign m_descr_addr  = r_descr_addr;
    assign m_descr_data  = r_descr_data;
    assign m_rptr        = r_rptr;
    assign m_outstanding = r_count;
    assign stat_issued   = r_stat_issued;
    assign stat_underrun = r_stat_underrun;

endmodule

// File: tb/tb_data_descr_sched_rb.sv
// Randomized bench for data_descr_sched_rb against a transaction-level model of ring pointers,
// the completion queue and the expected issue latency.
module tb_data_descr_sched_rb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_timeout;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [17:0] s_cmd_len_m1;
    logic        s_cmd_discard;
    logic [18:0] s_wptr;
    logic        m_descr_valid;
    logic        m_descr_ready;
    logic [16:0] m_descr_addr;
    logic [17:0] m_descr_data;
    logic        s_done_valid;
    logic [18:0] m_rptr;
    logic [3:0]  m_outstanding;
    logic [31:0] stat_issued;
    logic [31:0] stat_underrun;

    data_descr_sched_rb #(
        .RAM_ADDR_WIDTH(18),
        .DATA_BITS(3),
        .OUT_DEPTH_BITS(3),
        .TIMEOUT_BITS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_timeout(cfg_timeout),
        .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_len_m1(s_cmd_len_m1),
        .s_cmd_discard(s_cmd_discard),
        .s_wptr(s_wptr),
        .m_descr_valid(m_descr_valid),
        .m_descr_ready(m_descr_ready),
        .m_descr_addr(m_descr_addr),
        .m_descr_data(m_descr_data),
        .s_done_valid(s_done_valid),
        .m_rptr(m_rptr),
        .m_outstanding(m_outstanding),
        .stat_issued(stat_issued),
        .stat_underrun(stat_underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: ring pointers, in-flight spans in issue order, statistics.
    logic [18:0] m_iptr;
    logic [18:0] m_rptr_ref;
    logic [18:0] q[$];
    logic [31:0] m_issued;
    logic [31:0] m_under;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_iptr     = '0;
        m_rptr_ref = '0;
        q.delete();
        m_issued   = '0;
        m_under    = '0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        cfg_timeout   = '0;
        s_cmd_valid   = 1'b0;
        s_cmd_len_m1  = '0;
        s_cmd_discard = 1'b0;
        s_wptr        = '0;
        m_descr_ready = 1'b0;
        s_done_valid  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        model_reset();
        chk("rst_ready", s_cmd_ready, 1);
        chk("rst_valid", m_descr_valid, 0);
        chk("rst_rptr", m_rptr, 0);
        chk("rst_outstanding", m_outstanding, 0);
        chk("rst_issued", stat_issued, 0);
        chk("rst_underrun", stat_underrun, 0);
    endtask

    task automatic do_done();
        s_done_valid = 1'b1;
        tick();
        s_done_valid = 1'b0;
        if (q.size() > 0) m_rptr_ref = m_rptr_ref + q.pop_front();
        chk("done_rptr", m_rptr, m_rptr_ref);
        chk("done_outstanding", m_outstanding, q.size());
    endtask

    task automatic drain();
        while (q.size() > 0) do_done();
    endtask

    // One command: w0 is the write pointer presented with the command; if sup_dly >= 0 the
    // pointer moves to w1 that many cycles into the wait.
    task automatic run_cmd(input logic [17:0] len, input bit disc, input logic [18:0] w0,
                           input int sup_dly, input logic [18:0] w1, input logic [15:0] tmo,
                           input int hold, input bit done_with, input bit rst_mid);
        logic [18:0] sp;
        logic [18:0] av;
        logic [16:0] exp_addr;
        int          exp_lat;
        int          t;
        bit          tmo_hit;
        sp = (19'(len >> 3) + 19'd1) << 3;
        av = w0 - m_iptr;
        if (av >= sp) begin
            exp_lat = 1; tmo_hit = 0;
        end else if (sup_dly < 0) begin
            exp_lat = int'(tmo); tmo_hit = 1;
        end else if (tmo != 0 && int'(tmo) < sup_dly + 2) begin
            exp_lat = int'(tmo); tmo_hit = 1;
        end else begin
            exp_lat = sup_dly + 2; tmo_hit = 0;
        end
        exp_addr = {m_iptr[18:3], (tmo_hit ? 1'b1 : disc)};

        cfg_timeout   = tmo;
        s_wptr        = w0;
        s_cmd_len_m1  = len;
        s_cmd_discard = disc;
        s_cmd_valid   = 1'b1;
        chk("cmd_ready", s_cmd_ready, q.size() < 8);
        tick();
        s_cmd_valid   = 1'b0;
        s_cmd_discard = 1'b0;

        t = 0;
        while (!m_descr_valid && t < 100) begin
            if (t == sup_dly) s_wptr = w1;
            tick();
            t++;
        end
        chk("descr_latency", t, exp_lat);
        if (!m_descr_valid) return;

        for (int h = 0; h <= hold; h++) begin
            chk("descr_valid_hold", m_descr_valid, 1);
            chk("descr_addr", m_descr_addr, exp_addr);
            chk("descr_data", m_descr_data, len);
            if (h < hold) tick();
        end

        if (rst_mid) begin
            #2 rst = 1'b1;
            #1;
            model_reset();
            chk("midrst_valid", m_descr_valid, 0);
            chk("midrst_rptr", m_rptr, 0);
            chk("midrst_outstanding", m_outstanding, 0);
            chk("midrst_issued", stat_issued, 0);
            chk("midrst_underrun", stat_underrun, 0);
            s_wptr = '0;
            tick();
            rst = 1'b0;
            tick();
            chk("midrst_ready", s_cmd_ready, 1);
            return;
        end

        m_descr_ready = 1'b1;
        s_done_valid  = done_with;
        tick();
        m_descr_ready = 1'b0;
        s_done_valid  = 1'b0;
        if (done_with && q.size() > 0) m_rptr_ref = m_rptr_ref + q.pop_front();
        q.push_back(tmo_hit ? 19'd0 : sp);
        if (!tmo_hit) m_iptr = m_iptr + sp;
        m_issued = m_issued + 1;
        if (tmo_hit) m_under = m_under + 1;

        chk("post_valid", m_descr_valid, 0);
        chk("post_outstanding", m_outstanding, q.size());
        chk("post_rptr", m_rptr, m_rptr_ref);
        chk("post_issued", stat_issued, m_issued);
        chk("post_underrun", stat_underrun, m_under);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] len;
        logic [18:0] sp;
        logic [18:0] w0;
        logic [18:0] w1;
        logic [15:0] tmo;
        int          mode;
        int          sd;

        do_reset();

        // Basic read with data already resident.
        run_cmd(18'h7F, 0, 19'h100, -1, '0, 16'd0, 0, 0, 0);
        do_done();

        // Starved read: pointer sits at iptr, then two beats arrive.
        run_cmd(18'h0A, 0, m_iptr, 5, m_iptr + 19'h10, 16'd0, 0, 0, 0);

        // Underrun timeout with no data at all.
        run_cmd(18'h3F, 0, m_iptr, -1, '0, 16'd20, 0, 0, 0);
        drain();

        // Walk iptr up to 0x3FFC0 and then cross the ring wrap.
        run_cmd(18'h3FF2F, 0, 19'h3FFC0, -1, '0, 16'd0, 0, 0, 0);
        drain();
        run_cmd(18'h7F, 0, 19'h40040, -1, '0, 16'd0, 0, 0, 0);
        drain();

        // Commanded discard still waits for the data.
        run_cmd(18'h1F, 1, m_iptr + 19'h8, 3, m_iptr + 19'h20, 16'd0, 0, 0, 0);
        drain();

        // Fill the outstanding FIFO.
        for (int i = 0; i < 8; i++)
            run_cmd(18'(i * 8 + 3), 0, m_iptr + 19'h100, -1, '0, 16'd0, 0, 0, 0);
        chk("full_outstanding", m_outstanding, 8);
        s_cmd_valid  = 1'b1;
        s_cmd_len_m1 = 18'h7;
        s_wptr       = m_iptr + 19'h100;
        for (int i = 0; i < 3; i++) begin
            chk("full_ready", s_cmd_ready, 0);
            tick();
        end
        s_cmd_valid = 1'b0;
        chk("full_no_accept", m_outstanding, 8);
        do_done();
        run_cmd(18'h17, 0, m_iptr + 19'h40, -1, '0, 16'd0, 0, 1, 0);
        drain();
        do_done();

        // Backpressure: descriptor held for 10 cycles.
        run_cmd(18'h55, 1, m_iptr + 19'h80, -1, '0, 16'd0, 10, 0, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 70; i++) begin
            if (q.size() == 8) begin
                chk("rnd_full_ready", s_cmd_ready, 0);
                do_done();
            end
            len  = ($urandom_range(0, 9) == 0) ? 18'($urandom) : 18'($urandom_range(0, 12'hFFF));
            sp   = (19'(len >> 3) + 19'd1) << 3;
            mode = $urandom_range(0, 3);
            tmo  = '0;
            sd   = -1;
            w1   = '0;
            if (mode < 2) begin
                w0 = m_iptr + sp + 19'($urandom_range(0, 64));
            end else begin
                w0 = m_iptr + 19'($urandom % sp);
                if (mode == 2) begin
                    sd  = $urandom_range(0, 10);
                    w1  = m_iptr + sp + 19'($urandom_range(0, 32));
                    tmo = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 20));
                end else begin
                    tmo = 16'($urandom_range(1, 25));
                end
            end
            run_cmd(len, 1'($urandom_range(0, 1)), w0, sd, w1, tmo,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) do_done();
        end
        drain();

        // Reset while a descriptor is waiting for ready, then confirm iptr restarted at 0.
        run_cmd(18'h3F, 0, m_iptr + 19'h40, -1, '0, 16'd0, 2, 0, 1);
        run_cmd(18'h3F, 0, 19'h40, -1, '0, 16'd0, 0, 0, 0);
        do_done();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
